// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus receiver keeping a 2x16 shadow of the visible DDRAM.
// Define LCD_TIMING_CHECK_EN to enable the strobe gap checker.
module lcd_bus_monitor #(
  parameter int P_CLEAR_GAP = 15000,
  parameter int P_CMD_GAP   = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_LCD_DATA,
  input  logic       i_LCD_EN,
  input  logic       i_LCD_RS,
  input  logic       i_LCD_RW,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_busy,
  output logic       o_display_on,
  output logic       o_cmd_valid,
  output logic [7:0] o_cmd,
  output logic       o_wr_valid,
  output logic [4:0] o_wr_idx,
  output logic       o_overrun,
  output logic       o_err_timing
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       en_q;
  logic [9:0] lat_q, lat_d;
  logic [6:0] ac_q, ac_d;
  logic       acv_q, acv_d;
  logic       inc_q, inc_d;
  logic       disp_q, disp_d;
  logic [7:0] cmd_q, cmd_d;
  logic       cmdv_q, cmdv_d;
  logic       wrv_q, wrv_d;
  logic [4:0] wri_q, wri_d;
  logic       ovr_q, ovr_d;
  logic [7:0] rd_q;

  logic [7:0] mem_q [32];
  logic       mem_we;
  logic [4:0] mem_wa;
  logic [7:0] mem_wd;

  logic       lat_rs, lat_rw;
  logic [7:0] lat_dat;
  logic       fall, commit;

  assign lat_rs  = lat_q[9];
  assign lat_rw  = lat_q[8];
  assign lat_dat = lat_q[7:0];
  assign fall    = en_q & ~i_LCD_EN;
  assign commit  = (state_q == S_IDLE) & fall & ~lat_rw;

  // Two-line DDRAM map: 27<->40 and 67<->00 are adjacent.
  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       up
  );
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    ac_d    = ac_q;
    acv_d   = acv_q;
    inc_d   = inc_q;
    disp_d  = disp_q;
    cmd_d   = cmd_q;
    cmdv_d  = 1'b0;
    wrv_d   = 1'b0;
    wri_d   = wri_q;
    ovr_d   = ovr_q;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = 8'h20;
    if (i_LCD_EN)
      lat_d = {i_LCD_RS, i_LCD_RW, i_LCD_DATA};
    unique case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_d = S_IDLE;
        if (fall && !lat_rw)
          ovr_d = 1'b1;
      end
      S_IDLE: begin
        if (commit && lat_rs) begin
          if (acv_q && ac_q[5:4] == 2'b00) begin
            mem_we = 1'b1;
            mem_wa = {ac_q[6], ac_q[3:0]};
            mem_wd = lat_dat;
            wrv_d  = 1'b1;
            wri_d  = {ac_q[6], ac_q[3:0]};
          end
          ac_d = ac_step(ac_q, inc_q);
        end else if (commit) begin
          cmd_d  = lat_dat;
          cmdv_d = 1'b1;
          priority case (1'b1)
            lat_dat[7]: begin
              ac_d  = lat_dat[6:0];
              acv_d = 1'b1;
            end
            lat_dat[6]: acv_d = 1'b0;
            lat_dat[5]: ;
            lat_dat[4]: ;
            lat_dat[3]: disp_d = lat_dat[2];
            lat_dat[2]: inc_d = lat_dat[1];
            lat_dat[1]: begin
              ac_d  = 7'h00;
              acv_d = 1'b1;
            end
            lat_dat[0]: begin
              ac_d    = 7'h00;
              acv_d   = 1'b1;
              inc_d   = 1'b1;
              cnt_d   = 5'd0;
              state_d = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= 5'd0;
      en_q    <= 1'b0;
      lat_q   <= '0;
      ac_q    <= 7'h00;
      acv_q   <= 1'b1;
      inc_q   <= 1'b1;
      disp_q  <= 1'b0;
      cmd_q   <= 8'h00;
      cmdv_q  <= 1'b0;
      wrv_q   <= 1'b0;
      wri_q   <= 5'd0;
      ovr_q   <= 1'b0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= i_LCD_EN;
      lat_q   <= lat_d;
      ac_q    <= ac_d;
      acv_q   <= acv_d;
      inc_q   <= inc_d;
      disp_q  <= disp_d;
      cmd_q   <= cmd_d;
      cmdv_q  <= cmdv_d;
      wrv_q   <= wrv_d;
      wri_q   <= wri_d;
      ovr_q   <= ovr_d;
      rd_q    <= mem_q[i_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && mem_we)
      mem_q[mem_wa] <= mem_wd;
  end

`ifdef LCD_TIMING_CHECK_EN
  localparam logic [14:0] GapClr = 15'(P_CLEAR_GAP);
  localparam logic [14:0] GapCmd = 15'(P_CMD_GAP);

  logic [14:0] gap_q, gap_d;
  logic        plong_q, plong_d;
  logic        pfs_q, pfs_d;
  logic        err_q, err_d;
  logic        cur_fs, cur_long;

  assign cur_fs   = ~lat_rs & (lat_dat[7:5] == 3'b001);
  assign cur_long = ~lat_rs & (lat_dat[7:2] == 6'd0)
                  & (lat_dat[1] | lat_dat[0]);

  always_comb begin
    gap_d   = (gap_q == 15'h7fff) ? gap_q : gap_q + 15'd1;
    plong_d = plong_q;
    pfs_d   = pfs_q;
    err_d   = err_q;
    if (commit) begin
      gap_d   = 15'd0;
      plong_d = cur_long;
      pfs_d   = cur_fs;
      if (!cur_fs && !pfs_q &&
          (plong_q ? gap_q < GapClr : gap_q < GapCmd))
        err_d = 1'b1;
    end
  end

  // Gap starts saturated so the first strobe after reset is never flagged.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      gap_q   <= 15'h7fff;
      plong_q <= 1'b0;
      pfs_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      plong_q <= plong_d;
      pfs_q   <= pfs_d;
      err_q   <= err_d;
    end
  end

  assign o_err_timing = err_q;
`else
  assign o_err_timing = 1'b0;
`endif

  assign o_rd_data    = rd_q;
  assign o_busy       = (state_q == S_CLEAR);
  assign o_display_on = disp_q;
  assign o_cmd_valid  = cmdv_q;
  assign o_cmd        = cmd_q;
  assign o_wr_valid   = wrv_q;
  assign o_wr_idx     = wri_q;
  assign o_overrun    = ovr_q;

endmodule
